egd_seq_ctrl: RTL and testbench

Sequencer for the Exp-Golomb decode datapath. It buffers 16-bit bitstream words into a 32-bit MSB-first window and queues decode commands (ue/se/te/me select codes). For each command it presents a 16-bit aligned window to the decoder, starts it, waits for completion, and shifts out the consumed bits. Decoded values are returned to the requester through a valid/ready result port. It sits between the LA/host-side stimulus and the egd_top decoder core.

---
 rtl/egd_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_egd_seq_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egd_seq_ctrl.sv
// egd_seq_ctrl: sequencer for the Exp-Golomb decode datapath.
// Buffers 16-bit bitstream words into a 32-bit MSB-first window, queues
// select codes, runs one decode at a time and returns results.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   cmd_valid/ready/sel command push into the select-code FIFO
//   bs_valid/ready/data bitstream word fill into the window
//   dec_window/sel      aligned window[31:16] and active select code
//   dec_start           one-cycle decode start pulse
//   dec_done/len/value  decoder completion, bits consumed, value
//   res_valid/ready     result handshake, res_value/res_sel held
//   bits_avail          valid bits in the window (0..32)
//   busy, err           BUSY state indicator, sticky error flag
//
// Optional build macro EGD_SEQ_CTRL_TIMEOUT_EN: abort to HALT with err
// when dec_done has not arrived TIMEOUT_CYCLES cycles after dec_start.

module egd_seq_ctrl #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_sel,
    input  logic        bs_valid,
    output logic        bs_ready,
    input  logic [15:0] bs_data,
    output logic [15:0] dec_window,
    output logic [1:0]  dec_sel,
    output logic        dec_start,
    input  logic        dec_done,
    input  logic [4:0]  dec_len,
    input  logic [7:0]  dec_value,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_value,
    output logic [1:0]  res_sel,
    output logic [5:0]  bits_avail,
    output logic        busy,
    output logic        err
);

    localparam int unsigned PW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    generate
        if ((CMD_DEPTH < 2) || (CMD_DEPTH > 16) ||
            ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0) ||
            (TIMEOUT_CYCLES < 1)) begin : g_bad_param
            $error("egd_seq_ctrl: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   win_q, win_d;
    logic [5:0]    bits_q, bits_d;
    logic [1:0]    mem_q [CMD_DEPTH];
    logic [1:0]    mem_d [CMD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic [1:0]    sel_q, sel_d;
    logic          rv_q, rv_d;
    logic [7:0]    rval_q, rval_d;
    logic [1:0]    rsel_q, rsel_d;
    logic          err_q, err_d;

`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q, to_d;
`endif

    logic live;
    logic fifo_full;
    logic fifo_empty;
    logic cmd_rdy;
    logic bs_rdy;
    logic cmd_push;
    logic bs_push;
    logic len_ok;
    logic done_seen;
    logic pop;
    logic res_take;

    assign live       = !rst;
    assign fifo_full  = (cnt_q == CW'(CMD_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign cmd_rdy    = live && !fifo_full && (state_q != S_HALT);
    // Fills only in IDLE so a fill never collides with the post-decode shift.
    assign bs_rdy     = live && (state_q == S_IDLE) && (bits_q <= 6'd16);
    assign cmd_push   = cmd_valid && cmd_rdy;
    assign bs_push    = bs_valid && bs_rdy;
    assign len_ok     = (dec_len != 5'd0) && (dec_len <= 5'd16);
    // A done coinciding with the start pulse cannot belong to this decode.
    assign done_seen  = (state_q == S_BUSY) && dec_done && !start_q;
    assign pop        = done_seen && len_ok;
    assign res_take   = rv_q && res_ready;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        bits_d   = bits_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        sel_d    = sel_q;
        rv_d     = rv_q;
        rval_d   = rval_q;
        rsel_d   = rsel_q;
        err_d    = err_q;
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
        to_d     = to_q;
`endif

        if (cmd_push) begin
            mem_d[wr_ptr_q] = cmd_sel;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        // Bits below bits_avail are always zero, so OR-ing places the word.
        if (bs_push) begin
            win_d  = win_q | ({bs_data, 16'h0000} >> bits_q);
            bits_d = bits_q + 6'd16;
        end

        if (res_take) begin
            rv_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (bits_q >= 6'd16) && !rv_q) begin
                    state_d = S_BUSY;
                    start_d = 1'b1;
                    sel_d   = mem_q[rd_ptr_q];
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            S_BUSY: begin
                if (pop) begin
                    win_d    = win_q << dec_len;
                    bits_d   = bits_q - {1'b0, dec_len};
                    rv_d     = 1'b1;
                    rval_d   = dec_value;
                    rsel_d   = sel_q;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = S_IDLE;
                end else if (done_seen) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        cnt_d = cnt_q + CW'(cmd_push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            win_q    <= '0;
            bits_q   <= '0;
            mem_q    <= '{default: 2'b00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            sel_q    <= '0;
            rv_q     <= 1'b0;
            rval_q   <= '0;
            rsel_q   <= '0;
            err_q    <= 1'b0;
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            bits_q   <= bits_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            sel_q    <= sel_d;
            rv_q     <= rv_d;
            rval_q   <= rval_d;
            rsel_q   <= rsel_d;
            err_q    <= err_d;
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
            to_q     <= to_d;
`endif
        end
    end

    // Every output is forced low while reset is asserted.
    assign cmd_ready  = cmd_rdy;
    assign bs_ready   = bs_rdy;
    assign dec_window = live ? win_q[31:16] : 16'h0000;
    assign dec_sel    = live ? sel_q : 2'b00;
    assign dec_start  = live && start_q;
    assign res_valid  = live && rv_q;
    assign res_value  = live ? rval_q : 8'h00;
    assign res_sel    = live ? rsel_q : 2'b00;
    assign bits_avail = live ? bits_q : 6'd0;
    assign busy       = live && (state_q == S_BUSY);
    assign err        = live && err_q;

endmodule

// File: tb/tb_egd_seq_ctrl.sv
// tb_egd_seq_ctrl: directed bench for egd_seq_ctrl.
// Vector table for reset/basic decode, then FIFO, backpressure, error.

module tb_egd_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_sel;
    logic        bs_valid;
    logic        bs_ready;
    logic [15:0] bs_data;
    logic [15:0] dec_window;
    logic [1:0]  dec_sel;
    logic        dec_start;
    logic        dec_done;
    logic [4:0]  dec_len;
    logic [7:0]  dec_value;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_value;
    logic [1:0]  res_sel;
    logic [5:0]  bits_avail;
    logic        busy;
    logic        err;

    egd_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .bs_valid   (bs_valid),
        .bs_ready   (bs_ready),
        .bs_data    (bs_data),
        .dec_window (dec_window),
        .dec_sel    (dec_sel),
        .dec_start  (dec_start),
        .dec_done   (dec_done),
        .dec_len    (dec_len),
        .dec_value  (dec_value),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_value  (res_value),
        .res_sel    (res_sel),
        .bits_avail (bits_avail),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        cv;
        logic [1:0]  cs;
        logic        bv;
        logic [15:0] bd;
        logic        dd;
        logic [4:0]  dl;
        logic [7:0]  dv;
        logic        rr;
    } in_t;

    // Expected: {cmd_ready, bs_ready, dec_start, busy, err, res_valid,
    //            bits_avail, dec_window, res_value, res_sel}
    typedef struct {
        in_t         i;
        logic [37:0] e;
    } vec_t;

    vec_t        tv [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_start = 0;
    logic [31:0] m_win;
    logic [5:0]  m_bits;

    always @(negedge clk) begin
        if (dec_start) n_start <= n_start + 1;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input in_t v);
        rst       = v.rst;
        cmd_valid = v.cv;
        cmd_sel   = v.cs;
        bs_valid  = v.bv;
        bs_data   = v.bd;
        dec_done  = v.dd;
        dec_len   = v.dl;
        dec_value = v.dv;
        res_ready = v.rr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst    = 1'b0;
        m_win  = '0;
        m_bits = '0;
    endtask

    task automatic push_cmd(input logic [1:0] s);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [15:0] d);
        bit ok;
        ok       = 1'b0;
        bs_valid = 1'b1;
        bs_data  = d;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bs_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        bs_valid = 1'b0;
        check("feed_accept", 64'(ok), 64'(1));
        if (ok) begin
            m_win  = m_win | ({d, 16'h0000} >> m_bits);
            m_bits = m_bits + 6'd16;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dec_start) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_decode(input logic [1:0] s, input logic [4:0] len,
                             input logic [7:0] val, input int hold);
        bit ok;
        int bad;
        wait_start(ok);
        check("start_seen", 64'(ok), 64'(1));
        if (ok) begin
            check("dec_sel", 64'(dec_sel), 64'(s));
            check("dec_window", 64'(dec_window), 64'(m_win[31:16]));
            step();
            dec_done  = 1'b1;
            dec_len   = len;
            dec_value = val;
            step();
            dec_done = 1'b0;
            m_win    = m_win << len;
            m_bits   = m_bits - {1'b0, len};
            @(negedge clk);
            check("result", 64'({res_valid, res_value, res_sel}),
                  64'({1'b1, val, s}));
            check("bits_after", 64'(bits_avail), 64'(m_bits));
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                step();
                @(negedge clk);
                if (dec_start || !res_valid || res_value != val ||
                    res_sel != s) bad++;
            end
            if (hold > 0) check("hold_stable", 64'(bad), 64'(0));
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            @(negedge clk);
            check("res_clear", 64'(res_valid), 64'(0));
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          bad;
        int          base;
        int          found;
        logic [1:0]  sels [4];
        logic [37:0] act;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_sel = '0; bs_valid = 1'b0; bs_data = '0;
        dec_done = 1'b0; dec_len = '0; dec_value = '0; res_ready = 1'b0;

        tv.push_back('{{1'b1,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,16'h0000,8'h00,2'd0}});
        tv.push_back('{{1'b1,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6'd0,16'h0000,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,16'h0000,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b1,16'hA5C3,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd0,16'h0000,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b1,16'h1234,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,6'd16,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b1,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b1,5'd5,8'h77,1'b0}, {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b1,5'd3,8'h05,1'b0}, {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,6'd32,16'hA5C3,8'h00,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,6'd29,16'h2E18,8'h05,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b1}, {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,6'd29,16'h2E18,8'h05,2'd0}});
        tv.push_back('{{1'b0,1'b0,2'd0,1'b0,16'h0000,1'b0,5'd0,8'h00,1'b0}, {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,6'd29,16'h2E18,8'h05,2'd0}});

        base = n_start;
        for (int k = 0; k < tv.size(); k++) begin
            step();
            apply(tv[k].i);
            @(negedge clk);
            act = {cmd_ready, bs_ready, dec_start, busy, err, res_valid,
                   bits_avail, dec_window, res_value, res_sel};
            check($sformatf("vec%0d", k), 64'(act), 64'(tv[k].e));
        end
        step();
        apply('0);
        check("one_start", 64'(n_start - base), 64'(1));

        // FIFO full with no bitstream, then drain in order.
        do_reset();
        sels = '{2'd1, 2'd2, 2'd3, 2'd1};
        base = n_start;
        bad  = 0;
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1;
            cmd_sel   = sels[k];
            @(negedge clk);
            if (!cmd_ready) bad++;
            step();
        end
        check("fifo_push_rdy", 64'(bad), 64'(0));
        bad = 0;
        cmd_valid = 1'b1;
        cmd_sel   = 2'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (cmd_ready) bad++;
            step();
        end
        cmd_valid = 1'b0;
        check("fifo_full_rdy", 64'(bad), 64'(0));
        check("fifo_no_start", 64'(n_start - base), 64'(0));

        // Second word lands at bits_avail 16 in the IDLE->BUSY cycle.
        feed_word(16'h8421);
        feed_word(16'h1357);
        do_decode(2'd1, 5'd5, 8'h11, 8);
        do_decode(2'd2, 5'd11, 8'h22, 0);
        do_decode(2'd3, 5'd16, 8'h33, 0);
        feed_word(16'hC0DE);
        do_decode(2'd1, 5'd1, 8'h44, 0);
        feed_word(16'h5A5A);
        base = n_start;
        repeat (10) step();
        check("fifo_drained", 64'(n_start - base), 64'(0));
        check("bits_final", 64'(bits_avail), 64'(m_bits));

        // Zero-length completion halts the sequencer.
        do_reset();
        push_cmd(2'd2);
        feed_word(16'hABCD);
        wait_start(ok);
        check("err_start", 64'(ok), 64'(1));
        step();
        dec_done = 1'b1;
        dec_len  = 5'd0;
        step();
        dec_done = 1'b0;
        @(negedge clk);
        check("err_len0", 64'({err, busy, res_valid}), 64'({1'b1, 1'b0, 1'b0}));
        cmd_valid = 1'b1;
        bs_valid  = 1'b1;
        bad = 0;
        base = n_start;
        for (int k = 0; k < 20; k++) begin
            step();
            @(negedge clk);
            if (bs_ready || cmd_ready || dec_start || !err) bad++;
        end
        cmd_valid = 1'b0;
        bs_valid  = 1'b0;
        check("halt_quiet", 64'(bad), 64'(0));
        check("halt_no_start", 64'(n_start - base), 64'(0));
        check("halt_bits", 64'(bits_avail), 64'(16));
        step();
        do_reset();
        @(negedge clk);
        check("err_cleared", 64'({err, cmd_ready}), 64'({1'b0, 1'b1}));
        step();

        // Over-long completion also halts.
        push_cmd(2'd1);
        feed_word(16'hFFFF);
        wait_start(ok);
        step();
        dec_done = 1'b1;
        dec_len  = 5'd20;
        step();
        dec_done = 1'b0;
        @(negedge clk);
        check("err_len20", 64'({err, res_valid, bits_avail}),
              64'({1'b1, 1'b0, 6'd16}));
        step();

        // Decoder never answers.
        do_reset();
        push_cmd(2'd3);
        feed_word(16'h0F0F);
        wait_start(ok);
        check("to_start", 64'(ok), 64'(1));
        found = 0;
        for (int k = 1; k <= 45; k++) begin
            step();
            @(negedge clk);
            if (err) begin
                found = k;
                break;
            end
        end
`ifdef EGD_SEQ_CTRL_TIMEOUT_EN
        check("timeout_cycle", 64'(found), 64'(32));
        check("timeout_bits", 64'(bits_avail), 64'(16));
`else
        check("no_timeout", 64'(found), 64'(0));
        check("still_busy", 64'(busy), 64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
